// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle MULT/MULTU sequencer that borrows the shared ALU.
// The multiply is a 32-step shift-add with one ALU ADDU per cycle. The 64-bit
// product is returned on hi/lo, and busy stalls the core while the ALU is borrowed.
// Build option: define SIGNED_MULT_EN to support signed MULT. In that build,
// operand magnitudes are taken before the unsigned loop (NEG_IN, 2 cycles) and
// the product sign is restored afterwards (NEG_OUT, 2 cycles). Without the
// macro, op_signed is ignored and every request is unsigned.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int         CW       = $clog2(ITER + 1);
    localparam logic [3:0] ALU_ADDU = 4'b0010;

`ifdef SIGNED_MULT_EN
    localparam logic [3:0] ALU_SUBU = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_IN,
        S_RUN,
        S_NEG_OUT,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic             run_carry;

`ifdef SIGNED_MULT_EN
    // signed_q: the current request is MULT.
    // sign_res_q: the final product must be negated.
    // phase_q: selects the cycle within NEG_IN / NEG_OUT.
    logic             signed_q, signed_d;
    logic             sign_res_q, sign_res_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] neg_src;
`else
    // op_signed has no function in the unsigned-only build.
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
`endif

    // State and datapath registers; reset returns to IDLE with a cleared product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            count_q    <= '0;
`ifdef SIGNED_MULT_EN
            signed_q   <= 1'b0;
            sign_res_q <= 1'b0;
            phase_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            count_q    <= count_d;
`ifdef SIGNED_MULT_EN
            signed_q   <= signed_d;
            sign_res_q <= sign_res_d;
            phase_q    <= phase_d;
`endif
        end
    end

    // Next-state, datapath update and ALU drive. Outside busy states the ALU sees a harmless 0+0.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        count_d    = count_q;
        alu_op     = ALU_ADDU;
        alu_data1  = '0;
        alu_data2  = '0;
        run_carry  = 1'b0;
`ifdef SIGNED_MULT_EN
        signed_d   = signed_q;
        sign_res_d = sign_res_q;
        phase_d    = phase_q;
        neg_src    = '0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    count_d = '0;
`ifdef SIGNED_MULT_EN
                    signed_d   = op_signed;
                    sign_res_d = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    phase_d    = 1'b0;
                    state_d    = op_signed ? S_NEG_IN : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

`ifdef SIGNED_MULT_EN
            S_NEG_IN: begin
                // The multiplicand is converted first and the multiplier second.
                // A negative operand is negated as 0 - x; a positive one passes through as x + 0.
                neg_src = phase_q ? lo_q : mcand_q;
                if (neg_src[WIDTH-1]) begin
                    alu_op    = ALU_SUBU;
                    alu_data1 = '0;
                    alu_data2 = neg_src;
                end else begin
                    alu_op    = ALU_ADDU;
                    alu_data1 = neg_src;
                    alu_data2 = '0;
                end
                if (!phase_q) begin
                    mcand_d = alu_result;
                    phase_d = 1'b1;
                end else begin
                    lo_d    = alu_result;
                    phase_d = 1'b0;
                    state_d = S_RUN;
                end
            end
`endif

            S_RUN: begin
                // Add the multiplicand when the current multiplier bit is set.
                // The 33-bit partial sum then shifts right into hi/lo.
                alu_op    = ALU_ADDU;
                alu_data1 = hi_q;
                alu_data2 = lo_q[0] ? mcand_q : '0;
                run_carry = (alu_result < hi_q);
                hi_d      = {run_carry, alu_result[WIDTH-1:1]};
                lo_d      = {alu_result[0], lo_q[WIDTH-1:1]};
                count_d   = count_q + CW'(1);
                if (count_q == CW'(ITER - 1)) begin
`ifdef SIGNED_MULT_EN
                    state_d = signed_q ? S_NEG_OUT : S_DONE;
                    phase_d = 1'b0;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef SIGNED_MULT_EN
            S_NEG_OUT: begin
                // 64-bit two's-complement negate: lo = -lo, then hi = ~hi + (lo == 0).
                // Negation preserves zero, so testing the negated lo is the same as testing the original lo.
                // The stage always takes two cycles; for a positive result it just passes values through.
                if (!phase_q) begin
                    if (sign_res_q) begin
                        alu_op    = ALU_SUBU;
                        alu_data1 = '0;
                        alu_data2 = lo_q;
                    end else begin
                        alu_op    = ALU_ADDU;
                        alu_data1 = lo_q;
                        alu_data2 = '0;
                    end
                    lo_d    = alu_result;
                    phase_d = 1'b1;
                end else begin
                    alu_op = ALU_ADDU;
                    if (sign_res_q) begin
                        alu_data1 = ~hi_q;
                        alu_data2 = (lo_q == '0) ? WIDTH'(1) : '0;
                    end else begin
                        alu_data1 = hi_q;
                        alu_data2 = '0;
                    end
                    hi_d    = alu_result;
                    phase_d = 1'b0;
                    state_d = S_DONE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decode and the held product.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        alu_shamt = 5'd0;
        hi        = hi_q;
        lo        = lo_q;
        case (state_q)
            S_RUN:     busy = 1'b1;
`ifdef SIGNED_MULT_EN
            S_NEG_IN:  busy = 1'b1;
            S_NEG_OUT: busy = 1'b1;
`endif
            S_DONE:    done = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl. A behavioural ALU drives alu_result, and a
// scoreboard queue holds the expected products and latencies.
// Signed cases are built only when SIGNED_MULT_EN is defined.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic [31:0] alu_result;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    int nz_count   = 0;
    int done_count = 0;
    int shamt_bad  = 0;

`ifdef SIGNED_MULT_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    mul_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_signed  (op_signed),
        .alu_result (alu_result),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_op     (alu_op),
        .alu_shamt  (alu_shamt),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Shared ALU model: SUBU for 1011, ADDU otherwise.
    always_comb alu_result = (alu_op == 4'b1011) ? (alu_data1 - alu_data2) : (alu_data1 + alu_data2);

    always @(negedge clk) begin
        if (busy && alu_data2 != 32'd0) nz_count <= nz_count + 1;
        if (done) done_count <= done_count + 1;
        if (alu_shamt != 5'd0) shamt_bad <= shamt_bad + 1;
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (SIGNED_EN && s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Present one request and return #1 after the accepting edge; start is left high.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        op_a      = a;
        op_b      = b;
        op_signed = s;
        start     = 1'b1;
        exp_q.push_back(model(a, b, s));
        lat_q.push_back((SIGNED_EN && s) ? 36 : 32);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n, output bit to);
        n  = 0;
        to = 1'b0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
            if (n >= 100) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        start     = 1'b0;
        op_a      = 32'h1111_1111;
        op_b      = 32'h2222_2222;
        op_signed = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b want busy=0 done=0", busy, done);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_product: hi=%h lo=%h want 0/0", hi, lo);
        end
        total++;
        if (alu_op !== 4'b0010 || alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || alu_shamt !== 5'd0) begin
            bad++;
            $display("FAIL reset_alu_drive: op=%b d1=%h d2=%h sh=%h want 0010/0/0/0", alu_op, alu_data1, alu_data2, alu_shamt);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_unsigned;
        logic [31:0] ta[4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678};
        logic [31:0] tb[4] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0};
        int n;
        bit to;
        int nz0;
        int lat;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) begin
            nz0 = nz_count;
            issue(ta[i], tb[i], 1'b0);
            start = 1'b0;
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL unsigned_busy_after_accept[%0d]: busy=%b done=%b want 1/0", i, busy, done);
            end
            total++;
            if (alu_op !== 4'b0010) begin
                bad++;
                $display("FAIL unsigned_run_op[%0d]: alu_op=%b want 0010", i, alu_op);
            end
            wait_done(n, to);
            lat = lat_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (to) begin
                bad++;
                $display("FAIL unsigned_timeout[%0d]: no done within 100 cycles", i);
            end else if (n !== lat) begin
                bad++;
                $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, n, lat);
            end
            total++;
            if ({hi, lo} !== exp) begin
                bad++;
                $display("FAIL unsigned_product[%0d]: got %h_%h want %h", i, hi, lo, exp);
            end
            if (ta[i] == 32'd0) begin
                total++;
                if (nz_count !== nz0) begin
                    bad++;
                    $display("FAIL zero_operand_data2: nonzero alu_data2 seen %0d times want 0", nz_count - nz0);
                end
            end
            $display("txn unsigned a=%h b=%h hi=%h lo=%h lat=%0d", ta[i], tb[i], hi, lo, n);
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== exp) begin
                bad++;
                $display("FAIL unsigned_done_pulse[%0d]: done=%b busy=%b hi=%h lo=%h want 0/0 held %h", i, done, busy, hi, lo, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit to;
        int lat;
        logic [63:0] exp;
        issue(32'd9, 32'd11, 1'b0);
        @(negedge clk);
        op_a = 32'd7;
        op_b = 32'd6;
        exp_q.push_back(model(32'd7, 32'd6, 1'b0));
        lat_q.push_back(32);
        wait_done(n, to);
        lat = lat_q.pop_front();
        exp = exp_q.pop_front();
        total++;
        if (to || n !== lat) begin
            bad++;
            $display("FAIL held_start_latency: got %0d (timeout=%0d) want %0d", n, to, lat);
        end
        total++;
        if ({hi, lo} !== exp) begin
            bad++;
            $display("FAIL held_start_product: got %h_%h want %h", hi, lo, exp);
        end
        $display("txn held_start a=9 b=11 hi=%h lo=%h lat=%0d", hi, lo, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_accept: busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(n, to);
        lat = lat_q.pop_front();
        exp = exp_q.pop_front();
        total++;
        if (to || n !== lat) begin
            bad++;
            $display("FAIL back_to_back_latency: got %0d (timeout=%0d) want %0d", n, to, lat);
        end
        total++;
        if ({hi, lo} !== exp) begin
            bad++;
            $display("FAIL back_to_back_product: got %h_%h want %h", hi, lo, exp);
        end
        $display("txn back_to_back a=7 b=6 hi=%h lo=%h lat=%0d", hi, lo, n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n;
        bit to;
        int lat;
        int d0;
        logic [63:0] exp;
        issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.pop_back();
        lat_q.pop_back();
        d0 = done_count;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_immediate: busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (done_count !== d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done: done pulses=%0d busy=%b want 0/0", done_count - d0, busy);
        end
        $display("txn reset_mid: aborted run, busy=%b hi=%h lo=%h", busy, hi, lo);
        issue(32'd2, 32'd2, 1'b0);
        start = 1'b0;
        wait_done(n, to);
        lat = lat_q.pop_front();
        exp = exp_q.pop_front();
        total++;
        if (to || n !== lat) begin
            bad++;
            $display("FAIL after_reset_latency: got %0d (timeout=%0d) want %0d", n, to, lat);
        end
        total++;
        if ({hi, lo} !== exp) begin
            bad++;
            $display("FAIL after_reset_product: got %h_%h want %h", hi, lo, exp);
        end
        $display("txn after_reset a=2 b=2 hi=%h lo=%h lat=%0d", hi, lo, n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed;
`ifdef SIGNED_MULT_EN
        logic [31:0] ta[5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd5, 32'd3};
        logic [31:0] tb[5] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd5};
        logic        ts[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        logic [31:0] ta[2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] tb[2] = '{32'd5, 32'h8000_0000};
        logic        ts[2] = '{1'b1, 1'b1};
`endif
        int n;
        bit to;
        int lat;
        logic [63:0] exp;
        for (int i = 0; i < $size(ta); i++) begin
            issue(ta[i], tb[i], ts[i]);
            start = 1'b0;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL signed_busy_after_accept[%0d]: busy=%b want 1", i, busy);
            end
            wait_done(n, to);
            lat = lat_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (to || n !== lat) begin
                bad++;
                $display("FAIL signed_latency[%0d]: got %0d (timeout=%0d) want %0d", i, n, to, lat);
            end
            total++;
            if ({hi, lo} !== exp) begin
                bad++;
                $display("FAIL signed_product[%0d]: got %h_%h want %h", i, hi, lo, exp);
            end
            $display("txn signed a=%h b=%h s=%0d hi=%h lo=%h lat=%0d", ta[i], tb[i], ts[i], hi, lo, n);
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL signed_done_pulse[%0d]: done=%b want 0", i, done);
            end
        end
        op_signed = 1'b0;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_back_to_back;
        test_reset_mid;
        test_signed;
        total++;
        if (shamt_bad !== 0) begin
            bad++;
            $display("FAIL alu_shamt_const: nonzero shamt seen %0d times want 0", shamt_bad);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
